piso_serializer: RTL

Parallel-in, serial-out serializer. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `sdo`. It is the stage directly upstream of `shift_reg_siso`: `sdo` drives that block's `sdi`, and `sdo_en` marks the bit cycles that carry data. Back-to-back words stream with no idle gap.

---
 rtl/shift_reg_pkg.sv | 15 +
 rtl/piso_serializer_bit_counter.sv | 43 ++++
 rtl/piso_serializer.sv | 82 ++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family (piso_serializer,
// shift_reg_siso, future SIPO blocks).
//   ST_IDLE / ST_SHIFT : FSM state encodings
//   cnt_width()        : width of a bit counter that counts 0..width-1
package shift_reg_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // $clog2(width), but never less than one bit so a counter always exists.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter: loadable down-counter used to track bits left in a word.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset (count = 0, zero = 1)
//   load    : load WIDTH-1 (takes priority over dec)
//   dec     : decrement by one; ignored once the count reaches 0
//   zero    : count is 0 (registered flag)
module bit_counter
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   ONE      = CW'(1);

    logic [CW-1:0] cnt_q;
    logic          zero_q;

    // zero is kept as its own flop so downstream decode sees a clean,
    // glitch-free flag instead of a multi-bit compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (load) begin
            cnt_q  <= LOAD_VAL;
            zero_q <= 1'b0;   // WIDTH >= 2, so the load value is never 0
        end else if (dec && !zero_q) begin
            cnt_q  <= cnt_q - ONE;
            zero_q <= (cnt_q == ONE);
        end
    end

    assign zero = zero_q;

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out serializer with valid/ready input.
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   din       : parallel word (WIDTH bits), sampled only on accept
//   din_valid : din holds a word
//   din_ready : a word can be accepted this cycle (idle or last-bit cycle)
//   sdo       : serial data out (flop output)
//   sdo_en    : sdo carries a data bit this cycle
//   done      : high while the last bit of a word is on sdo
// Back-to-back words stream without a gap: a new word is loaded on the edge
// that ends the previous word's last bit.
module piso_serializer
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdo,
    output logic             sdo_en,
    output logic             done
);

    logic [0:0]       state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_shift;
    logic             sdo_en_q;
    logic             last_bit;
    logic             accept;
    logic             cnt_dec;

    assign din_ready = (state_q == ST_IDLE) || last_bit;
    assign accept    = din_valid && din_ready;
    assign cnt_dec   = (state_q == ST_SHIFT) && !last_bit;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .dec     (cnt_dec),
        .zero    (last_bit)
    );

    // Move the next bit into the output position, zero-filling behind it.
    always_comb begin
        if (MSB_FIRST) begin
            sreg_shift = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shift = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    // Leaving SHIFT clears the shift register so sdo idles at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            sdo_en_q <= 1'b0;
        end else if (accept) begin
            state_q  <= ST_SHIFT;
            sreg_q   <= din;
            sdo_en_q <= 1'b1;
        end else if ((state_q == ST_SHIFT) && !last_bit) begin
            sreg_q   <= sreg_shift;
        end else begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            sdo_en_q <= 1'b0;
        end
    end

    assign sdo    = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign sdo_en = sdo_en_q;
    assign done   = (state_q == ST_SHIFT) && last_bit;

endmodule
